// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding and the hard-wired $zero register index.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN   = 2'd0,
        CTRL_STALL = 2'd1,
        CTRL_FLUSH = 2'd2
    } ctrl_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         SB_W     = 2;

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Per-register pending-write scoreboard: 31 two-bit down-counters.
// It has one load port and two combinational busy lookups. Register 0 is never busy.
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int WB_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ld_en,
    input  logic [4:0] i_ld_reg,
    input  logic [4:0] i_rd_a,
    input  logic [4:0] i_rd_b,
    output logic       o_busy_a,
    output logic       o_busy_b
);

    // The issue edge is the first of the WB_LAT cycles, so the counter starts one lower.
    localparam logic [SB_W-1:0] LOAD_VAL = SB_W'(WB_LAT - 1);

    logic [SB_W-1:0] r_sb [1:31];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 1; r < 32; r++) r_sb[r] <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (i_ld_en && (i_ld_reg == 5'(r)))
                    r_sb[r] <= LOAD_VAL;
                else if (r_sb[r] != '0)
                    r_sb[r] <= r_sb[r] - 1'b1;
            end
        end
    end

    always_comb begin
        o_busy_a = 1'b0;
        o_busy_b = 1'b0;
        for (int r = 1; r < 32; r++) begin
            if ((i_rd_a == 5'(r)) && (r_sb[r] != '0)) o_busy_a = 1'b1;
            if ((i_rd_b == 5'(r)) && (r_sb[r] != '0)) o_busy_b = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flush sequencer for the 5-stage core without forwarding.
// It holds the RUN/STALL/FLUSH FSM, the flush counter, the Mealy output decode and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int WB_LAT    = 3,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_vld,
    input  logic [4:0]       dec_rs,
    input  logic [4:0]       dec_rt,
    input  logic             dec_use_rs,
    input  logic             dec_use_rt,
    input  logic             dec_wreg,
    input  logic [4:0]       dec_destR,
    input  logic             br_taken,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             issue,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] FCNT_LOAD = 2'(FLUSH_CYC - 1);

    ctrl_state_e      r_state, w_state_next;
    logic [1:0]       r_fcnt, w_fcnt_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_busy_rs, w_busy_rt;
    logic             w_hazard, w_flush, w_ld_en;

    hazard_scoreboard #(.WB_LAT(WB_LAT)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .i_ld_en  (w_ld_en),
        .i_ld_reg (dec_destR),
        .i_rd_a   (dec_rs),
        .i_rd_b   (dec_rt),
        .o_busy_a (w_busy_rs),
        .o_busy_b (w_busy_rt)
    );

    assign w_hazard = dec_vld & ((dec_use_rs & w_busy_rs) | (dec_use_rt & w_busy_rt));
    assign w_flush  = br_taken | (r_state == CTRL_FLUSH);
    // Gating with rst keeps every control output low while reset is held.
    assign pc_stall    = rst & w_hazard & ~w_flush;
    assign ifid_stall  = pc_stall;
    assign ifid_flush  = rst & w_flush;
    assign idex_bubble = rst & (w_hazard | w_flush);
    assign issue       = rst & dec_vld & ~w_hazard & ~w_flush;
    assign w_ld_en     = issue & dec_wreg & (dec_destR != REG_ZERO);
    assign ctrl_state  = r_state;
    assign stall_cnt   = r_stall_cnt;

    always_comb begin
        w_state_next = r_state;
        w_fcnt_next  = r_fcnt;
        case (r_state)
            CTRL_FLUSH: begin
                if (br_taken)
                    w_fcnt_next = FCNT_LOAD;
                else if (r_fcnt == 2'd0)
                    w_state_next = CTRL_RUN;
                else
                    w_fcnt_next = r_fcnt - 2'd1;
            end
            default: begin
                if (br_taken) begin
                    w_state_next = CTRL_FLUSH;
                    w_fcnt_next  = FCNT_LOAD;
                end else if (w_hazard) begin
                    w_state_next = CTRL_STALL;
                end else begin
                    w_state_next = CTRL_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= CTRL_RUN;
            r_fcnt      <= 2'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_fcnt  <= w_fcnt_next;
            if (pc_stall && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a reference model pushes expected outputs per cycle.
// A narrow-counter second instance sees the same stimulus so that the saturation check runs quickly.
module tb_pipe_hazard_ctrl;

    localparam int WB_LAT    = 3;
    localparam int FLUSH_CYC = 1;

    typedef struct {
        string       tag;
        logic        pcStall;
        logic        ifidFlush;
        logic        idexBubble;
        logic        issue;
        logic [1:0]  state;
        logic [15:0] cnt;
        logic [3:0]  satCnt;
    } expT;

    logic        clk = 1'b0;
    logic        rst;
    logic        decVld, decUseRs, decUseRt, decWreg, brTaken;
    logic [4:0]  decRs, decRt, decDest;
    logic        pcStall, ifidStall, ifidFlush, idexBubble, issue;
    logic [1:0]  ctrlState;
    logic [15:0] stallCnt;
    logic        sPcStall, sIfidStall, sIfidFlush, sIdexBubble, sIssue;
    logic [1:0]  sCtrlState;
    logic [3:0]  sStallCnt;

    int  testCount = 0;
    int  failCount = 0;
    expT expQ[$];

    int mSb[32];
    int mState, mFcnt, mCnt, mSat;
    logic mHazard, mFlush, mIssue, mPcStall;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.WB_LAT(WB_LAT), .FLUSH_CYC(FLUSH_CYC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .dec_vld(decVld), .dec_rs(decRs), .dec_rt(decRt),
        .dec_use_rs(decUseRs), .dec_use_rt(decUseRt), .dec_wreg(decWreg),
        .dec_destR(decDest), .br_taken(brTaken), .pc_stall(pcStall),
        .ifid_stall(ifidStall), .ifid_flush(ifidFlush), .idex_bubble(idexBubble),
        .issue(issue), .ctrl_state(ctrlState), .stall_cnt(stallCnt)
    );

    pipe_hazard_ctrl #(.WB_LAT(WB_LAT), .FLUSH_CYC(FLUSH_CYC), .CNT_W(4)) dutSat (
        .clk(clk), .rst(rst), .dec_vld(decVld), .dec_rs(decRs), .dec_rt(decRt),
        .dec_use_rs(decUseRs), .dec_use_rt(decUseRt), .dec_wreg(decWreg),
        .dec_destR(decDest), .br_taken(brTaken), .pc_stall(sPcStall),
        .ifid_stall(sIfidStall), .ifid_flush(sIfidFlush), .idex_bubble(sIdexBubble),
        .issue(sIssue), .ctrl_state(sCtrlState), .stall_cnt(sStallCnt)
    );

    // Counts one comparison and reports it if the observed value differs from the expected value.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: reset clears everything; otherwise derive the combinational outputs from model state.
    task automatic modelEval();
        if (!rst) begin
            for (int r = 0; r < 32; r++) mSb[r] = 0;
            mState = 0; mFcnt = 0; mCnt = 0; mSat = 0;
            mHazard = 0; mFlush = 0; mIssue = 0; mPcStall = 0;
        end else begin
            mHazard = decVld && ((decUseRs && decRs != 0 && mSb[decRs] != 0) ||
                                 (decUseRt && decRt != 0 && mSb[decRt] != 0));
            mFlush   = brTaken || (mState == 2);
            mPcStall = mHazard && !mFlush;
            mIssue   = decVld && !mHazard && !mFlush;
        end
    endtask

    // Model update for the next rising edge.
    task automatic modelStep();
        if (!rst) return;
        for (int r = 1; r < 32; r++) if (mSb[r] > 0) mSb[r]--;
        if (mIssue && decWreg && decDest != 0) mSb[decDest] = WB_LAT - 1;
        if (mPcStall) begin
            if (mCnt < 65535) mCnt++;
            if (mSat < 15) mSat++;
        end
        if (mState == 2) begin
            if (brTaken) mFcnt = FLUSH_CYC - 1;
            else if (mFcnt == 0) mState = 0;
            else mFcnt--;
        end else if (brTaken) begin
            mState = 2;
            mFcnt  = FLUSH_CYC - 1;
        end else begin
            mState = mHazard ? 1 : 0;
        end
    endtask

    // Drive one decode cycle, queue its expected outputs, compare at the falling edge, then advance.
    task automatic applyStimulus(input logic vld, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urs, input logic urt, input logic wreg,
                                 input logic [4:0] dest, input logic br, input string tag);
        expT e, o;
        decVld = vld; decRs = rs; decRt = rt; decUseRs = urs; decUseRt = urt;
        decWreg = wreg; decDest = dest; brTaken = br;
        modelEval();
        e.tag = tag;
        e.pcStall = mPcStall;
        e.ifidFlush = mFlush;
        e.idexBubble = rst && (mHazard || mFlush);
        e.issue = mIssue;
        e.state = 2'(mState);
        e.cnt = 16'(mCnt);
        e.satCnt = 4'(mSat);
        expQ.push_back(e);
        @(negedge clk);
        o = expQ.pop_front();
        checkOutput({o.tag, ".pc_stall"}, 32'(pcStall), 32'(o.pcStall));
        checkOutput({o.tag, ".ifid_stall"}, 32'(ifidStall), 32'(o.pcStall));
        checkOutput({o.tag, ".ifid_flush"}, 32'(ifidFlush), 32'(o.ifidFlush));
        checkOutput({o.tag, ".idex_bubble"}, 32'(idexBubble), 32'(o.idexBubble));
        checkOutput({o.tag, ".issue"}, 32'(issue), 32'(o.issue));
        checkOutput({o.tag, ".state"}, 32'(ctrlState), 32'(o.state));
        checkOutput({o.tag, ".stall_cnt"}, 32'(stallCnt), 32'(o.cnt));
        checkOutput({o.tag, ".sat_cnt"}, 32'(sStallCnt), 32'(o.satCnt));
        modelStep();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        decVld = 0; decRs = 0; decRt = 0; decUseRs = 0; decUseRt = 0;
        decWreg = 0; decDest = 0; brTaken = 0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 1, "rst_held");
        rst = 1'b1;

        // Reset in the middle of a pending write to r5, then r5 must read as free.
        applyStimulus(1, 5'd0, 5'd0, 0, 0, 1, 5'd5, 0, "t1_wr5");
        rst = 1'b0;
        applyStimulus(1, 5'd5, 5'd0, 1, 0, 0, 5'd0, 0, "t1_in_rst");
        rst = 1'b1;
        applyStimulus(1, 5'd5, 5'd0, 1, 0, 0, 5'd0, 0, "t1_after_rst");

        // RAW on r3: two stall cycles, then issue.
        applyStimulus(1, 5'd0, 5'd0, 0, 0, 1, 5'd3, 0, "t2_wr3");
        repeat (3) applyStimulus(1, 5'd3, 5'd0, 1, 0, 0, 5'd0, 0, "t2_rd3");

        // Independent sources issue back to back.
        applyStimulus(1, 5'd0, 5'd0, 0, 0, 1, 5'd3, 0, "t3_wr3");
        applyStimulus(1, 5'd4, 5'd5, 1, 1, 0, 5'd0, 0, "t3_rd45");

        // Writes to $zero are never scoreboarded.
        applyStimulus(1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, "t4_wr0");
        applyStimulus(1, 5'd0, 5'd0, 1, 1, 0, 5'd0, 0, "t4_rd0");

        // Branch during a hazard: flush wins and the killed write to r9 is dropped.
        applyStimulus(1, 5'd0, 5'd0, 0, 0, 1, 5'd7, 0, "t5_wr7");
        applyStimulus(1, 5'd7, 5'd0, 1, 0, 1, 5'd9, 1, "t5_br_haz");
        applyStimulus(1, 5'd9, 5'd0, 1, 0, 0, 5'd0, 0, "t5_flush");
        applyStimulus(1, 5'd9, 5'd0, 1, 0, 0, 5'd0, 0, "t5_rd9");

        // Branch arriving while in STALL.
        applyStimulus(1, 5'd0, 5'd0, 0, 0, 1, 5'd8, 0, "t5b_wr8");
        applyStimulus(1, 5'd0, 5'd8, 0, 1, 0, 5'd0, 0, "t5b_stall");
        applyStimulus(1, 5'd0, 5'd8, 0, 1, 0, 5'd0, 1, "t5b_br");
        applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, "t5b_br_again");
        applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, "t5b_flush");
        applyStimulus(1, 5'd8, 5'd0, 1, 0, 0, 5'd0, 0, "t5b_run");

        // Self-dependent instruction repeated: drives the narrow counter into saturation.
        repeat (30) applyStimulus(1, 5'd6, 5'd0, 1, 0, 1, 5'd6, 0, "t6_sat");

        for (int i = 0; i < 300; i++) begin
            applyStimulus(logic'($urandom_range(0, 7) != 0),
                          5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
                          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                          logic'($urandom_range(0, 1)), 5'($urandom_range(0, 4)),
                          logic'($urandom_range(0, 9) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
